mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit datapath: PC, instruction register, register file, ALU and data memory.
- Replaces the single-cycle opcode decoder. One shared memory port serves both fetch and data access, so each instruction runs over 3-5 states.
- Sits between the instruction register (opcode/funct in) and the datapath muxes, enables and ALU control (out). Also counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- WAIT_MAX, 15, cycles a memory state waits for mem_ready before flagging timeout (0 = never time out).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  start/continue; sampled only in IDLE and at FETCH entry.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_src  out  2  0=ALU result, 1=ALUOut reg, 2=jump target.
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR.
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut.
- reg_dst  out  1  1=rd, 0=rt.
- reg_write  out  1  register write enable.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=const 4, 2=zero-ext imm, 3=imm<<2.
- alu_op  out  2  0=add, 1=sub, 2=use funct.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- mem_timeout  out  1  sticky; cleared only by reset.
- retired  out  CNT_W  instructions completed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, retired=0, mem_timeout=0, wait counter=0. All outputs 0.
- Outputs are Moore on state. Exceptions: ir_write and pc_write in FETCH = mem_ready. reg_write in MEM_WB is unconditional.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- IDLE: all outputs 0. Go to FETCH when en=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. Hold until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
  - LW/SW/ADDI -> MEM_ADDR.
  - R -> EXEC_R.
  - BEQ -> BRANCH.
  - J -> JUMP.
  - Other: pulse illegal_op, go to FETCH, retired unchanged.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: LW -> MEM_RD, SW -> MEM_WR, ADDI -> ADDI_WB.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready. Retire on exit.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. Retire.
- JUMP: pc_write=1, pc_src=2. Retire.
- Retire: retired += 1 (wraps modulo 2^CNT_W). Next state FETCH if en=1, else IDLE.
- en=0 mid-instruction is ignored; the instruction completes.
- Memory wait: counter increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0, and clears on state exit.
  - Reaching WAIT_MAX: set mem_timeout, go to IDLE, no retire.
  - mem_ready=1 on the same cycle as reaching WAIT_MAX: completion wins.
- rst asserted mid-instruction: immediate return to IDLE. Partial writes are suppressed because outputs drop to 0 combinationally from state.

Decomposition:
- Shared package/include scp_defs: state encoding, opcode constants, alu_op/alu_src_b/pc_src encodings.
- Sub-module mc_op_decode (combinational): opcode -> one-hot class {r, lw, sw, beq, j, addi, illegal}. Instantiated once.

Test Plan:
- Reset, then en=1, opcode=000000, mem_ready=1 always -> states FETCH, DECODE, EXEC_R, R_WB. reg_write=1 and reg_dst=1 in cycle 4. retired 0->1.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held 4 cycles. MEM_WB asserts mem_to_reg=1. Total 5 + 3 cycles.
- BEQ, zero=1 -> BRANCH cycle shows pc_write_cond=1, pc_src=1, alu_op=1. J -> pc_write=1, pc_src=2. Each adds 1 to retired.
- opcode=111111 -> illegal_op pulses 1 cycle in DECODE. Next state FETCH. retired unchanged.
- WAIT_MAX=15, mem_ready=0 in FETCH for 15 cycles -> mem_timeout=1, busy=0. Repeat with mem_ready=1 on cycle 15 -> DECODE, no timeout.
- rst pulsed low during MEM_WR -> mem_write drops to 0 asynchronously, retired=0, state IDLE.

Source files
------------

// File: rtl/scp_defs.sv
// Shared definitions for the multi-cycle sequencer.
// Holds the FSM state encoding, opcode constants, datapath mux/ALU encodings
// and the one-hot opcode class produced by mc_op_decode.
package scp_defs;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StRWb,
    StAddiWb,
    StBranch,
    StJump
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluSub   = 2'd1;
  localparam logic [1:0] AluFunct = 2'd2;

  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  // Exactly one field is set for any opcode.
  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic addi;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode   in  6  IR[31:26]
//   op_class out    one-hot instruction class {r, lw, sw, beq, j, addi, illegal}
module mc_op_decode
  import scp_defs::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OpR:     op_class.r       = 1'b1;
      OpLw:    op_class.lw      = 1'b1;
      OpSw:    op_class.sw      = 1'b1;
      OpBeq:   op_class.beq     = 1'b1;
      OpJ:     op_class.j       = 1'b1;
      OpAddi:  op_class.addi    = 1'b1;
      default: op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM for the 32-bit datapath with a shared memory port.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   en                       start/continue, sampled in IDLE and when retiring
//   opcode, funct, zero      IR fields and ALU zero flag (funct/zero consumed downstream)
//   mem_ready                memory access completes this cycle
//   pc_write..alu_op         datapath enables, mux selects and ALU control (Moore on state)
//   illegal_op               one-cycle pulse in DECODE on an unknown opcode
//   mem_timeout              sticky, set when a memory state waits WAIT_MAX cycles
//   retired                  count of completed instructions (wraps)
//   busy                     state != IDLE
module mc_sequencer
  import scp_defs::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  // Wait counter only has to hold WAIT_MAX-1 before the timeout fires.
  localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q;
  logic               timeout_q;
  logic               retire, timeout_set, wait_hit;
  op_class_t          op_class;

  // funct drives ALU control and zero gates PC loads outside this block.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  mc_op_decode u_op_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // This not-ready cycle is the WAIT_MAX-th; mem_ready in the same cycle still wins.
  assign wait_hit = (WAIT_MAX != 0) && ((32'(wait_q) + 32'd1) == 32'(WAIT_MAX));

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    retire        = 1'b0;
    timeout_set   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PcAlu;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRt;
    alu_op        = AluAdd;
    illegal_op    = 1'b0;

    if ((state_q == StFetch || state_q == StMemRd || state_q == StMemWr) &&
        !mem_ready && !wait_hit && (WAIT_MAX != 0)) begin
      wait_d = wait_q + WaitW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StFetch;
      end
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_hit) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
        if (op_class.lw || op_class.sw || op_class.addi) state_d = StMemAddr;
        else if (op_class.r)                             state_d = StExecR;
        else if (op_class.beq)                           state_d = StBranch;
        else if (op_class.j)                             state_d = StJump;
        else begin
          illegal_op = 1'b1;
          state_d    = StFetch;
        end
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        if (op_class.lw)        state_d = StMemRd;
        else if (op_class.sw)   state_d = StMemWr;
        else if (op_class.addi) state_d = StAddiWb;
        else                    state_d = StIdle;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (wait_hit) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
        end else if (wait_hit) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_src        = PcAluOut;
        retire        = 1'b1;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcJump;
        retire   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (retire) state_d = en ? StFetch : StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      retired_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  assign retired     = retired_q;
  assign mem_timeout = timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

  localparam int unsigned CW = 8;
  localparam int unsigned WM = 15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic clk = 1'b0;
  logic rst, en, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout, busy;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .retired(retired), .busy(busy)
  );

  typedef struct packed {
    logic pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic illegal_op, mem_timeout, busy;
    logic [CW-1:0] retired;
  } outs_t;

  typedef struct packed {
    logic en, ready, zero;
    logic [5:0] opcode, funct;
  } stim_t;

  stim_t stim_q[$];
  outs_t exp_q[$];
  string name_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model state: instructions retired and sticky timeout.
  logic [CW-1:0] m_ret;
  logic m_to;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int classify(input logic [5:0] op);
    case (op)
      OP_R: return 0;
      OP_LW: return 1;
      OP_SW: return 2;
      OP_BEQ: return 3;
      OP_J: return 4;
      OP_ADDI: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic outs_t busy_base();
    outs_t e = '0;
    e.busy = 1'b1;
    e.retired = m_ret;
    e.mem_timeout = m_to;
    return e;
  endfunction

  function automatic outs_t got();
    outs_t g;
    g.pc_write = pc_write; g.pc_write_cond = pc_write_cond; g.pc_src = pc_src;
    g.i_or_d = i_or_d; g.mem_read = mem_read; g.mem_write = mem_write;
    g.ir_write = ir_write; g.mem_to_reg = mem_to_reg; g.reg_dst = reg_dst;
    g.reg_write = reg_write; g.alu_src_a = alu_src_a; g.alu_src_b = alu_src_b;
    g.alu_op = alu_op; g.illegal_op = illegal_op; g.mem_timeout = mem_timeout;
    g.busy = busy; g.retired = retired;
    return g;
  endfunction

  task automatic check(input string nm, input outs_t g, input outs_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, g, e);
    end
  endtask

  task automatic push(input logic en_v, input logic rdy, input logic [5:0] op,
                      input outs_t e, input string nm);
    stim_t s;
    s.en = en_v; s.ready = rdy; s.opcode = op; s.funct = 6'($urandom); s.zero = rb();
    stim_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Idle cycles with en low, raised on the last so the next cycle is a fetch.
  task automatic push_idle(input int n);
    outs_t e = '0;
    e.retired = m_ret;
    e.mem_timeout = m_to;
    for (int i = 0; i < n; i++) push((i == n - 1), rb(), 6'($urandom), e, "idle");
  endtask

  task automatic gen_instr(input logic [5:0] op, input int d_fetch, input int d_mem,
                           input logic en_next);
    outs_t e;
    int cls = classify(op);
    e = busy_base(); e.mem_read = 1; e.alu_src_b = 2'd1;
    for (int i = 0; i < d_fetch; i++) push(rb(), 1'b0, op, e, "fetch_wait");
    e.ir_write = 1; e.pc_write = 1;
    push(rb(), 1'b1, op, e, "fetch_done");
    e = busy_base(); e.alu_src_b = 2'd3;
    if (cls == 6) begin
      e.illegal_op = 1;
      push(rb(), rb(), op, e, "decode_illegal");
      return;
    end
    push(rb(), rb(), op, e, "decode");
    if (cls == 1 || cls == 2 || cls == 5) begin
      e = busy_base(); e.alu_src_a = 1; e.alu_src_b = 2'd2;
      push(rb(), rb(), op, e, "mem_addr");
    end
    e = busy_base();
    case (cls)
      0: begin
        e.alu_src_a = 1; e.alu_op = 2'd2;
        push(rb(), rb(), op, e, "exec_r");
        e = busy_base(); e.reg_write = 1; e.reg_dst = 1;
        push(en_next, rb(), op, e, "r_wb");
      end
      1: begin
        e.mem_read = 1; e.i_or_d = 1;
        for (int i = 0; i < d_mem; i++) push(rb(), 1'b0, op, e, "mem_rd_wait");
        push(rb(), 1'b1, op, e, "mem_rd_done");
        e = busy_base(); e.reg_write = 1; e.mem_to_reg = 1;
        push(en_next, rb(), op, e, "mem_wb");
      end
      2: begin
        e.mem_write = 1; e.i_or_d = 1;
        for (int i = 0; i < d_mem; i++) push(rb(), 1'b0, op, e, "mem_wr_wait");
        push(en_next, 1'b1, op, e, "mem_wr_done");
      end
      3: begin
        e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_write_cond = 1; e.pc_src = 2'd1;
        push(en_next, rb(), op, e, "branch");
      end
      4: begin
        e.pc_write = 1; e.pc_src = 2'd2;
        push(en_next, rb(), op, e, "jump");
      end
      default: begin
        e.reg_write = 1;
        push(en_next, rb(), op, e, "addi_wb");
      end
    endcase
    m_ret = m_ret + 1'b1;
    if (!en_next) push_idle($urandom_range(1, 3));
  endtask

  task automatic gen_timeout();
    outs_t e;
    e = busy_base(); e.mem_read = 1; e.alu_src_b = 2'd1;
    for (int i = 0; i < int'(WM); i++) push(rb(), 1'b0, OP_R, e, "fetch_timeout_wait");
    m_to = 1'b1;
    e = '0; e.retired = m_ret; e.mem_timeout = 1'b1;
    push(1'b0, rb(), OP_R, e, "timeout_idle");
    push(1'b0, rb(), OP_R, e, "timeout_idle2");
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[6];
    logic [5:0] op;
    int k;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
    k = $urandom_range(0, 6);
    if (k < 6) return ops[k];
    op = 6'($urandom);
    while (classify(op) != 6) op = 6'($urandom);
    return op;
  endfunction

  initial begin
    int n;
    bit found;
    rst = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    m_ret = '0; m_to = 1'b0;

    // Stimulus plan with expected responses.
    push_idle(1);
    gen_instr(OP_R, 0, 0, 1'b1);
    gen_instr(OP_LW, 0, 3, 1'b1);
    gen_instr(OP_BEQ, 1, 0, 1'b1);
    gen_instr(OP_J, 0, 0, 1'b0);
    gen_instr(6'b111111, 0, 0, 1'b1);
    gen_instr(OP_SW, 14, 14, 1'b1);
    gen_instr(OP_LW, 2, 14, 1'b1);
    for (int i = 0; i < 300; i++)
      gen_instr(rand_op(), $urandom_range(0, 4), $urandom_range(0, 4),
                ($urandom_range(0, 3) != 0));
    gen_timeout();

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", got(), '0);
    rst = 1'b1;
    n = stim_q.size();

    fork
      begin : driver
        stim_t s;
        for (int i = 0; i < n; i++) begin
          s = stim_q.pop_front();
          en = s.en; mem_ready = s.ready; opcode = s.opcode; funct = s.funct; zero = s.zero;
          @(posedge clk);
          #1;
        end
      end
      begin : monitor
        outs_t e;
        string nm;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, got(), e);
        end
      end
    join

    // Asynchronous reset in the middle of a store.
    en = 1'b1; opcode = OP_SW; mem_ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (mem_write === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_mem_wr got=mem_write_never_seen exp=mem_write_1");
    end else begin
      rst = 1'b0;
      #1;
      check("reset_mid_mem_wr", got(), '0);
    end
    rst = 1'b1;
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
